// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and scan-code constants.
// The key-to-note decoder imports the same package for its break and extend prefixes.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

   localparam int PS2_FRAME_LEN = 11;
   localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronisers for the PS/2 pins plus a FILTER_LEN-sample glitch filter
// on the clock line that emits a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data_sync
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic          filt_q, filt_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Only an unbroken run of samples that disagree with the filtered level counts.
   always_comb begin
      filt_d = filt_q;
      fall_d = 1'b0;
      cnt_d  = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fall_d = filt_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         filt_q      <= filt_d;
         fall_q      <= fall_d;
         cnt_q       <= cnt_d;
      end
   end

   assign fall      = fall_q;
   assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames into one-cycle scan-code pulses.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key,
   output logic       key_valid,
   output logic       rx_err,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic fall;
   logic data_s;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .fall      (fall),
      .data_sync (data_s)
   );

   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          rx_err_q, rx_err_d;
   logic          frame_ok;
   logic          tmo_hit;

`ifdef PS2_PARITY_CHECK_EN
   logic par_q, par_d;
   assign frame_ok = data_s && ps2_parity_ok(shreg_q, par_q);
`else
   assign frame_ok = data_s;
`endif

   assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      key_d       = '0;
      key_valid_d = 1'b0;
      rx_err_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d       = par_q;
`endif
      tmo_d = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
      // A stalled frame is abandoned even if an edge arrives in the same cycle.
      if (tmo_hit) begin
         rx_err_d = 1'b1;
         shreg_d  = '0;
         state_d  = IDLE;
         tmo_d    = '0;
      end else if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                  shreg_d   = '0;
               end
            end
            DATA: begin
               shreg_d   = {data_s, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d   = data_s;
`endif
               state_d = STOP;
            end
            STOP: begin
               if (frame_ok) begin
                  key_d       = shreg_q;
                  key_valid_d = 1'b1;
               end else begin
                  rx_err_d    = 1'b1;
               end
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         tmo_q       <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         rx_err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         tmo_q       <= tmo_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         rx_err_q    <= rx_err_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= par_d;
`endif
      end
   end

   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign rx_err    = rx_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames push expected pulses, a monitor pops them.
// PS/2 timing is scaled (100-cycle bit period, 1000-cycle timeout) to keep runs short.
module tb_ps2_rx;
   import ps2_pkg::*;

   localparam int FLEN = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 50;
   localparam int LAT  = 11;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      bit         is_err;
      logic [7:0] key;
      int         lo;
      int         hi;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key;
   logic       key_valid;
   logic       rx_err;
   logic       busy;

   exp_t sb[$];
   int   nvec = 0;
   int   nbad = 0;
   int   cyc = 0;
   int   last_fall = 0;

   ps2_rx #(
      .FILTER_LEN  (FLEN),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key       (key),
      .key_valid (key_valid),
      .rx_err    (rx_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest expectation.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!key_valid) check("key_idle_zero", {24'd0, key}, 32'd0);
            if (key_valid || rx_err) begin
               nvec++;
               if (sb.size() == 0) begin
                  nbad++;
                  $display("FAIL unexpected_pulse: kv=%0b err=%0b key=%0h cyc=%0d required no pulse",
                           key_valid, rx_err, key, cyc);
               end else begin
                  e = sb.pop_front();
                  if (key_valid === e.is_err || rx_err !== e.is_err ||
                      (!e.is_err && key !== e.key) || busy !== 1'b0 ||
                      cyc < e.lo || cyc > e.hi) begin
                     nbad++;
                     $display("FAIL pulse: got kv=%0b err=%0b key=%0h busy=%0b cyc=%0d required kv=%0b err=%0b key=%0h busy=0 cyc=%0d..%0d",
                              key_valid, rx_err, key, busy, cyc,
                              !e.is_err, e.is_err, e.key, e.lo, e.hi);
                  end
               end
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int nbits, input bit glitch, input bit exp_err);
      logic [10:0] fr;
      exp_t        e;
      fr = {s, p, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         if (glitch && i == 5) begin
            repeat (20) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 23) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk   = 1'b0;
         last_fall = cyc;
         if (i == 10) begin
            e.is_err = exp_err;
            e.key    = exp_err ? 8'h00 : d;
            e.lo     = cyc + LAT - 2;
            e.hi     = cyc + LAT + 2;
            sb.push_back(e);
         end
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 32'd0);
   endtask

   initial begin : stim
      exp_t e;
      repeat (3) @(negedge clk);
      check("rst_key", {24'd0, key}, 32'd0);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_rx_err", {31'd0, rx_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      drain(200);
      check("busy_after_1c", {31'd0, busy}, 32'd0);

      send_frame(PS2_BREAK_CODE, 1'b1, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      drain(200);

      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, PAR_EN);
      drain(200);

      send_frame(8'h15, 1'b0, 1'b0, 11, 1'b0, 1'b1);
      send_frame(8'h15, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      drain(200);

      send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      e.is_err = 1'b1;
      e.key    = 8'h00;
      e.lo     = last_fall + TMO + LAT - 2;
      e.hi     = last_fall + TMO + LAT + 2;
      sb.push_back(e);
      drain(TMO + 200);
      check("busy_after_timeout", {31'd0, busy}, 32'd0);
      send_frame(8'h24, 1'b1, 1'b1, 11, 1'b0, 1'b0);
      drain(200);

      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
      drain(200);

      send_frame(8'hAA, 1'b0, 1'b1, 4, 1'b0, 1'b0);
      check("busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_key", {24'd0, key}, 32'd0);
      check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
      check("midrst_rx_err", {31'd0, rx_err}, 32'd0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (TMO + 100) @(negedge clk);
      check("busy_after_rst", {31'd0, busy}, 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      drain(200);

      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
